// File: rtl/vga_char_writer.sv
// ---------------------------------------------------------------------------
// vga_char_writer
//
// Writes one 8x8 text cell into the VGA frame buffer (ram2port write port).
// A character command is latched, its 8 glyph rows are read from an external
// synchronous font ROM, and the rows are packed into the two 32-bit words that
// hold the cell. A clear request zero-fills the whole frame buffer instead.
//
// Ports:
//   CLK_25      pixel-domain clock (only clock)
//   Reset       synchronous, active-high reset
//   char_valid  command valid            char_ready  block idle, can accept
//   char_code   ASCII code (7b)          char_col    text column (7b)
//   char_row    text row (6b)            char_inv    1 = invert glyph
//   clr_req     clear-screen request     char_drop   1-cycle pulse, command discarded
//   font_addr   {code, glyph_line}       font_data   glyph row, 1 cycle after address
//   wraddress   frame-buffer word addr   data        frame-buffer write data
//   wren        frame-buffer write enable
//
// Handshake: a command transfers on a rising edge where char_valid and
// char_ready are both 1 and clr_req is 0. char_ready is only 1 in IDLE.
// clr_req is only looked at in IDLE and wins over a simultaneous char_valid;
// the command is then not consumed and upstream keeps it valid.
// ---------------------------------------------------------------------------
module vga_char_writer #(
    parameter int COLS     = 80,
    parameter int ROWS     = 60,
    parameter int FB_WORDS = 9600
) (
    input  logic        CLK_25,
    input  logic        Reset,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [6:0]  char_code,
    input  logic [6:0]  char_col,
    input  logic [5:0]  char_row,
    input  logic        char_inv,
    input  logic        clr_req,
    output logic        char_drop,
    output logic [9:0]  font_addr,
    input  logic [7:0]  font_data,
    output logic [13:0] wraddress,
    output logic [31:0] data,
    output logic        wren
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_WAIT_WR = 2'd2;
    localparam logic [1:0] S_CLEAR   = 2'd3;

    // Each text row spans two word rows: glyph lines 0-3, then lines 4-7.
    localparam logic [13:0] ROW_STRIDE  = 14'(2 * COLS);
    localparam logic [13:0] HALF_STRIDE = 14'(COLS);
    localparam logic [13:0] LAST_ADDR   = 14'(FB_WORDS - 1);

    logic [1:0]  state_q, state_d;
    // Cycles since transfer: holds k during cycle T+k of a character write.
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  code_q, code_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic        inv_q, inv_d;
    logic        ready_q, ready_d;
    logic        drop_q, drop_d;
    logic        wren_q, wren_d;
    logic [13:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [9:0]  font_addr_q, font_addr_d;

    logic        in_range;
    logic [13:0] addr_a0;
    logic [13:0] addr_a1;
    logic [7:0]  glyph_bits;
    logic [1:0]  lane;
    logic        capture;

    assign in_range = (int'(char_col) < COLS) && (int'(char_row) < ROWS);
    assign addr_a0  = 14'(row_q) * ROW_STRIDE + 14'(col_q);
    assign addr_a1  = addr_a0 + HALF_STRIDE;

    // ROM bit 7 is the leftmost pixel, which lands on the lowest bit of its lane.
    always_comb begin
        glyph_bits = '0;
        for (int k = 0; k < 8; k++) begin
            glyph_bits[k] = font_data[7 - k] ^ inv_q;
        end
    end

    // Line requested in cycle T+j returns in T+j+1, so in cycle T+k the ROM
    // output holds line k-2. Lines 0-3 are complete for the A0 write in T+6;
    // lines 4-7 overwrite the same lanes in time for the A1 write in T+10.
    assign lane    = 2'(cnt_q - 4'd2);
    assign capture = ((state_q == S_FETCH) && (cnt_q >= 4'd2)) ||
                     ((state_q == S_WAIT_WR) && (cnt_q == 4'd9));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        col_d       = col_q;
        row_d       = row_q;
        inv_d       = inv_q;
        ready_d     = ready_q;
        drop_d      = 1'b0;
        wren_d      = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        font_addr_d = font_addr_q;

        if (capture) begin
            data_d[{lane, 3'b000} +: 8] = glyph_bits;
        end

        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    ready_d = 1'b0;
                    wren_d  = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
                end else if (char_valid) begin
                    if (!in_range) begin
                        // Consumed but discarded: no ROM reads, no writes.
                        drop_d = 1'b1;
                    end else begin
                        state_d     = S_FETCH;
                        ready_d     = 1'b0;
                        cnt_d       = 4'd1;
                        code_d      = char_code;
                        col_d       = char_col;
                        row_d       = char_row;
                        inv_d       = char_inv;
                        font_addr_d = {char_code, 3'd0};
                    end
                end
            end
            S_FETCH: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q < 4'd8) begin
                    font_addr_d = {code_q, cnt_q[2:0]};
                end else begin
                    state_d = S_WAIT_WR;
                end
                if (cnt_q == 4'd5) begin
                    wren_d = 1'b1;
                    addr_d = addr_a0;
                end
            end
            S_WAIT_WR: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    wren_d = 1'b1;
                    addr_d = addr_a1;
                end else begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    wren_d = 1'b1;
                    addr_d = addr_q + 14'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_25) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            inv_q       <= 1'b0;
            ready_q     <= 1'b1;
            drop_q      <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            font_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            col_q       <= col_d;
            row_q       <= row_d;
            inv_q       <= inv_d;
            ready_q     <= ready_d;
            drop_q      <= drop_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            font_addr_q <= font_addr_d;
        end
    end

    assign char_ready = ready_q;
    assign char_drop  = drop_q;
    assign wren       = wren_q;
    assign wraddress  = addr_q;
    assign data       = data_q;
    assign font_addr  = font_addr_q;

endmodule

// File: tb/tb_vga_char_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_char_writer
//
// Directed bench for vga_char_writer. A cycle-level model records what the
// outputs must be relative to the cycle each command was accepted; a single
// compare process checks the DUT against it every cycle, and the expected
// frame-buffer writes are kept in a scoreboard queue. Literal expectations
// pin down the model for the key cases.
// ---------------------------------------------------------------------------
module tb_vga_char_writer;

  localparam int COLS_TB  = 80;
  localparam int ROWS_TB  = 60;
  localparam int CLR_N    = 9600;
  localparam int BUDGET   = 20000;

  localparam int M_RST  = 0;
  localparam int M_CHAR = 1;
  localparam int M_DROP = 2;
  localparam int M_CLR  = 3;

  logic        CLK_25;
  logic        Reset;
  logic        char_valid;
  logic        char_ready;
  logic [6:0]  char_code;
  logic [6:0]  char_col;
  logic [5:0]  char_row;
  logic        char_inv;
  logic        clr_req;
  logic        char_drop;
  logic [9:0]  font_addr;
  logic [7:0]  font_data;
  logic [13:0] wraddress;
  logic [31:0] data;
  logic        wren;

  vga_char_writer #(.COLS(80), .ROWS(60), .FB_WORDS(9600)) dut (
    .CLK_25     (CLK_25),
    .Reset      (Reset),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_code  (char_code),
    .char_col   (char_col),
    .char_row   (char_row),
    .char_inv   (char_inv),
    .clr_req    (clr_req),
    .char_drop  (char_drop),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .wraddress  (wraddress),
    .data       (data),
    .wren       (wren)
  );

  // ---------------- clock / reset / counters ----------------
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  initial begin
    CLK_25 = 1'b0;
    forever #5 CLK_25 = ~CLK_25;
  end

  always @(posedge CLK_25) cyc <= cyc + 1;

  // Font ROM: line l of every glyph is 0x01 << l, one-cycle read latency.
  always @(posedge CLK_25) font_data <= 8'h01 << font_addr[2:0];

  // ---------------- model ----------------
  int          mdl_mode = M_RST;
  int          mdl_t0 = 0;
  logic [6:0]  mdl_code = '0;
  logic [9:0]  fa_hold = '0;
  logic [45:0] exp_q[$];
  logic [45:0] obs_q[$];

  function automatic logic [7:0] glyph_row(input int line);
    return 8'h01 << line;
  endfunction

  // Pixel x of a glyph line is bit (7-x) of the ROM row; it lives in bit
  // x of the byte lane for that line.
  function automatic logic [31:0] pack_half(input int first_line, input logic inv);
    logic [31:0] w;
    logic [7:0]  g;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      g = glyph_row(first_line + l);
      for (int x = 0; x < 8; x++) w[l * 8 + x] = g[7 - x] ^ inv;
    end
    return w;
  endfunction

  task automatic leave_mode();
    if (mdl_mode == M_CHAR) fa_hold = {mdl_code, 3'd7};
  endtask

  task automatic model_cmd(input logic [6:0] code, input logic [6:0] col,
                           input logic [5:0] row, input logic inv, input int t);
    int a0;
    leave_mode();
    mdl_t0 = t;
    if (int'(col) >= COLS_TB || int'(row) >= ROWS_TB) begin
      mdl_mode = M_DROP;
    end else begin
      mdl_mode = M_CHAR;
      mdl_code = code;
      a0 = 2 * int'(row) * COLS_TB + int'(col);
      exp_q.push_back({14'(a0), pack_half(0, inv)});
      exp_q.push_back({14'(a0 + COLS_TB), pack_half(4, inv)});
    end
  endtask

  task automatic model_clear(input int t);
    leave_mode();
    mdl_mode = M_CLR;
    mdl_t0 = t;
    for (int a = 0; a < CLR_N; a++) exp_q.push_back({14'(a), 32'h0});
  endtask

  task automatic model_reset(input int t);
    mdl_mode = M_RST;
    mdl_t0 = t;
    fa_hold = '0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int          d;
  logic        e_ready, e_wren, e_drop;
  logic [45:0] e_wr;

  always @(negedge CLK_25) begin
    if (chk_en) begin
      d = cyc - mdl_t0;
      e_ready = 1'b1;
      e_wren  = 1'b0;
      e_drop  = 1'b0;
      case (mdl_mode)
        M_CHAR: begin
          e_ready = (d >= 11);
          e_wren  = (d == 6) || (d == 10);
        end
        M_DROP: e_drop = (d == 1);
        M_CLR: begin
          e_ready = (d > CLR_N);
          e_wren  = (d >= 1) && (d <= CLR_N);
        end
        default: ;
      endcase
      chk("char_ready", 64'(char_ready), 64'(e_ready));
      chk("wren", 64'(wren), 64'(e_wren));
      chk("char_drop", 64'(char_drop), 64'(e_drop));
      if (mdl_mode == M_CHAR && d >= 1 && d <= 8)
        chk("font_addr", 64'(font_addr), 64'({mdl_code, 3'(d - 1)}));
      if (mdl_mode == M_DROP)
        chk("font_addr_hold", 64'(font_addr), 64'(fa_hold));
      if (mdl_mode == M_RST) begin
        chk("rst_font_addr", 64'(font_addr), 64'h0);
        chk("rst_wraddress", 64'(wraddress), 64'h0);
        chk("rst_data", 64'(data), 64'h0);
      end
      if (wren === 1'b1) begin
        obs_q.push_back({wraddress, data});
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL write_unexpected: got addr %0d data %0h expected no write (cycle %0d)",
                   wraddress, data, cyc);
        end else begin
          e_wr = exp_q.pop_front();
          chk("write", 64'({wraddress, data}), 64'(e_wr));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge CLK_25);
    #1;
  endtask

  // Waits (bounded) for a transfer; returns the transfer cycle or -1.
  task automatic wait_ready(input string name, output int t);
    t = -1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge CLK_25);
      if (char_ready === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got no char_ready expected ready within %0d cycles", name, BUDGET);
    end
  endtask

  task automatic send_char(input logic [6:0] code, input logic [6:0] col,
                           input logic [5:0] row, input logic inv,
                           input bit keep, output int t);
    char_code  = code;
    char_col   = col;
    char_row   = row;
    char_inv   = inv;
    char_valid = 1'b1;
    wait_ready("send_char", t);
    if (t < 0) begin
      char_valid = 1'b0;
      return;
    end
    @(posedge CLK_25);
    model_cmd(code, col, row, inv, t);
    #1;
    if (!keep) char_valid = 1'b0;
  endtask

  task automatic send_clear(output int t);
    clr_req = 1'b1;
    wait_ready("clear", t);
    if (t < 0) begin
      clr_req = 1'b0;
      return;
    end
    @(posedge CLK_25);
    model_clear(t);
    #1;
    clr_req = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int t0, t1, t2;

  initial begin
    Reset      = 1'b1;
    char_valid = 1'b0;
    char_code  = '0;
    char_col   = '0;
    char_row   = '0;
    char_inv   = 1'b0;
    clr_req    = 1'b0;
    repeat (3) @(posedge CLK_25);
    #1;
    chk_en = 1'b1;
    idle(2);
    Reset = 1'b0;
    idle(2);

    // 'H' at col 1, row 0, not inverted.
    obs_q.delete();
    send_char(7'h48, 7'd1, 6'd0, 1'b0, 1'b0, t0);
    idle(12);
    chk("h_write_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() >= 2) begin
      chk("h_a0", 64'(obs_q[0]), 64'({14'd1, 32'h10204080}));
      chk("h_a1", 64'(obs_q[1]), 64'({14'd81, 32'h01020408}));
    end

    // Bottom-right cell, inverted.
    obs_q.delete();
    send_char(7'h48, 7'd79, 6'd59, 1'b1, 1'b0, t0);
    idle(12);
    chk("corner_write_count", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() >= 2) begin
      chk("corner_a0", 64'(obs_q[0]), 64'({14'd9519, 32'hEFDFBF7F}));
      chk("corner_a1", 64'(obs_q[1]), 64'({14'd9599, 32'hFEFDFBF7}));
    end

    // Out-of-range column, then out-of-range row.
    obs_q.delete();
    send_char(7'h41, 7'd80, 6'd0, 1'b0, 1'b0, t0);
    idle(3);
    send_char(7'h41, 7'd0, 6'd60, 1'b0, 1'b0, t0);
    idle(3);
    chk("drop_no_writes", 64'(obs_q.size()), 64'd0);
    chk("drop_font_addr", 64'(font_addr), 64'h247);

    // Clear with a character pending: clear wins, character follows.
    obs_q.delete();
    char_code  = 7'h5A;
    char_col   = 7'd2;
    char_row   = 6'd3;
    char_inv   = 1'b0;
    char_valid = 1'b1;
    send_clear(t0);
    send_char(7'h5A, 7'd2, 6'd3, 1'b0, 1'b0, t1);
    chk("clear_duration", 64'(t1 - t0), 64'd9601);
    chk("clear_write_count", 64'(obs_q.size()), 64'd9600);
    if (obs_q.size() >= 9600) begin
      chk("clear_first", 64'(obs_q[0]), 64'({14'd0, 32'h0}));
      chk("clear_last", 64'(obs_q[9599]), 64'({14'd9599, 32'h0}));
    end
    idle(12);
    if (obs_q.size() >= 9602)
      chk("after_clear_a0", 64'(obs_q[9600]), 64'({14'd482, 32'h10204080}));

    // Reset during cycle T+7 of a write: only A0 lands.
    obs_q.delete();
    send_char(7'h48, 7'd1, 6'd0, 1'b0, 1'b0, t0);
    repeat (6) @(posedge CLK_25);
    #1;
    Reset = 1'b1;
    @(posedge CLK_25);
    model_reset(t0 + 7);
    repeat (2) @(posedge CLK_25);
    #1;
    Reset = 1'b0;
    idle(12);
    chk("rst_write_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() >= 1)
      chk("rst_a0_only", 64'(obs_q[0]), 64'({14'd1, 32'h10204080}));

    // Back-to-back with char_valid held high.
    obs_q.delete();
    send_char(7'h41, 7'd0, 6'd0, 1'b0, 1'b1, t0);
    send_char(7'h42, 7'd5, 6'd10, 1'b1, 1'b1, t1);
    send_char(7'h43, 7'd79, 6'd0, 1'b0, 1'b0, t2);
    idle(14);
    chk("b2b_gap1", 64'(t1 - t0), 64'd11);
    chk("b2b_gap2", 64'(t2 - t1), 64'd11);
    chk("b2b_write_count", 64'(obs_q.size()), 64'd6);
    if (obs_q.size() >= 6) begin
      chk("b2b_addr0", 64'(obs_q[0][45:32]), 64'd0);
      chk("b2b_addr1", 64'(obs_q[1][45:32]), 64'd80);
      chk("b2b_addr2", 64'(obs_q[2][45:32]), 64'd1605);
      chk("b2b_addr3", 64'(obs_q[3][45:32]), 64'd1685);
      chk("b2b_addr4", 64'(obs_q[4][45:32]), 64'd79);
      chk("b2b_addr5", 64'(obs_q[5][45:32]), 64'd159);
      chk("b2b_data2", 64'(obs_q[2][31:0]), 64'h EFDFBF7F);
    end

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
